// File: rtl/id_operand_pipe.sv
// ---------------------------------------------------------------------------
// id_operand_pipe
//   ID-stage operand generator with the ID/EX pipeline register.
//   Selects operand_1/operand_2 per opcode from the register file, the EX/MEM
//   bypass paths, the immediate field or the PC. The result is registered
//   behind a valid/ready handshake. Load-use hazards block acceptance, and
//   stalled cycles are counted in a saturating counter.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      decoded instruction handshake (upstream)
//   op, imm, pc              opcode, immediate (DATA_W/2), instruction PC
//   rs_addr, rt_addr         source register addresses
//   reg_data_1, reg_data_2   register-file reads for rs / rt
//   ex_we/ex_waddr/ex_wdata/ex_is_load   EX-stage bypass source
//   mem_we/mem_waddr/mem_wdata           MEM-stage bypass source
//   out_valid / out_ready    ID/EX handshake (downstream)
//   operand_1, operand_2     registered operands
//   load_use_stall           combinational hazard indication
//   stall_cycles             saturating count of stalled cycles
// ---------------------------------------------------------------------------
module id_operand_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int OP_W        = 6,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        op,
  input  logic [DATA_W/2-1:0]    imm,
  input  logic [DATA_W-1:0]      pc,
  input  logic [REG_ADDR_W-1:0]  rs_addr,
  input  logic [REG_ADDR_W-1:0]  rt_addr,
  input  logic [DATA_W-1:0]      reg_data_1,
  input  logic [DATA_W-1:0]      reg_data_2,
  input  logic                   ex_we,
  input  logic [REG_ADDR_W-1:0]  ex_waddr,
  input  logic [DATA_W-1:0]      ex_wdata,
  input  logic                   ex_is_load,
  input  logic                   mem_we,
  input  logic [REG_ADDR_W-1:0]  mem_waddr,
  input  logic [DATA_W-1:0]      mem_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      operand_1,
  output logic [DATA_W-1:0]      operand_2,
  output logic                   load_use_stall,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int HW = DATA_W / 2;

  localparam logic [OP_W-1:0] OP_SPECIAL = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_JAL     = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_BEQ     = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE     = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDIU   = OP_W'(6'b001001);
  localparam logic [OP_W-1:0] OP_ORI     = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LUI     = OP_W'(6'b001111);

  // Bypass resolution for one source. A pending load in EX is not a hit:
  // its data is not ready yet, and the hazard logic stalls instead.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_W-1:0]     rf
  );
    if (addr == '0)
      resolve = '0;
    else if (ex_we && !ex_is_load && ex_waddr == addr)
      resolve = ex_wdata;
    else if (mem_we && mem_waddr == addr)
      resolve = mem_wdata;
    else
      resolve = rf;
  endfunction

  // Source index 0 = rs, 1 = rt.
  logic [1:0][REG_ADDR_W-1:0] src_addr;
  logic [1:0][DATA_W-1:0]     rf_data;
  logic [1:0][DATA_W-1:0]     src_data;

  assign src_addr = {rt_addr, rs_addr};
  assign rf_data  = {reg_data_2, reg_data_1};

  for (genvar g = 0; g < 2; g++) begin : g_src
    assign src_data[g] = resolve(src_addr[g], rf_data[g]);
  end

  logic use_rs, use_rt;
  logic [DATA_W-1:0] op1_d, op2_d;

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    op1_d  = '0;
    op2_d  = '0;
    case (op)
      OP_ADDIU: begin
        use_rs = 1'b1;
        op1_d  = src_data[0];
        op2_d  = {{HW{imm[HW-1]}}, imm};
      end
      OP_ORI: begin
        use_rs = 1'b1;
        op1_d  = src_data[0];
        op2_d  = {{HW{1'b0}}, imm};
      end
      OP_LUI: begin
        op2_d  = {imm, {HW{1'b0}}};
      end
      OP_BEQ, OP_BNE, OP_SPECIAL: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        op1_d  = src_data[0];
        op2_d  = src_data[1];
      end
      OP_JAL: begin
        op1_d  = pc + DATA_W'(8);   // wraps modulo 2^DATA_W
      end
      default: ;
    endcase
  end

  assign load_use_stall = in_valid && ex_we && ex_is_load && (ex_waddr != '0) &&
                          ((use_rs && ex_waddr == rs_addr) ||
                           (use_rt && ex_waddr == rt_addr));

  logic                   out_valid_q;
  logic [DATA_W-1:0]      op1_q, op2_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   accept;

  assign in_ready = (!out_valid_q || out_ready) && !load_use_stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      stall_q     <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        op1_q       <= op1_d;
        op2_q       <= op2_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (load_use_stall && stall_q != {STALL_CNT_W{1'b1}})
        stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign out_valid    = out_valid_q;
  assign operand_1    = op1_q;
  assign operand_2    = op2_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_operand_pipe.sv
// Directed bench for id_operand_pipe. Inputs change on the falling edge;
// combinational outputs are checked 1 ns later, registered outputs on the
// falling edge after the capturing rising edge. The stall counter is
// narrowed to 4 bits so saturation is reachable in a few cycles.
module tb_id_operand_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 6;
  localparam int CW = 4;

  localparam logic [OW-1:0] SPECIAL = 6'b000000, JAL = 6'b000011,
                            BEQ = 6'b000100, ADDIU = 6'b001001,
                            ORI = 6'b001101, LUI = 6'b001111;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid, in_ready, out_valid, out_ready, load_use_stall;
  logic [OW-1:0] op;
  logic [DW/2-1:0] imm;
  logic [DW-1:0] pc, reg_data_1, reg_data_2, ex_wdata, mem_wdata, operand_1, operand_2;
  logic [AW-1:0] rs_addr, rt_addr, ex_waddr, mem_waddr;
  logic          ex_we, ex_is_load, mem_we;
  logic [CW-1:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  id_operand_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .OP_W(OW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .imm(imm), .pc(pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .ex_we(ex_we),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .operand_1(operand_1),
    .operand_2(operand_2), .load_use_stall(load_use_stall),
    .stall_cycles(stall_cycles));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    in_valid = 0; op = 6'b111111; imm = '0; pc = '0; rs_addr = '0; rt_addr = '0;
    reg_data_1 = '0; reg_data_2 = '0; ex_we = 0; ex_waddr = '0; ex_wdata = '0;
    ex_is_load = 0; mem_we = 0; mem_waddr = '0; mem_wdata = '0; out_ready = 1;
  endtask

  // One rising edge, then land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an instruction, capture it, check the registered operands.
  task automatic issue(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    in_valid = 1;
    #1 chk({tag, " in_ready"}, in_ready, 1'b1);
    step();
    in_valid = 0;
    chk({tag, " out_valid"}, out_valid, 1'b1);
    chk({tag, " op1"}, operand_1, e1);
    chk({tag, " op2"}, operand_2, e2);
  endtask

  initial begin
    clr();
    step();
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst op1", operand_1, 32'h0);
    chk("rst op2", operand_2, 32'h0);
    chk("rst stall", stall_cycles, 4'd0);
    rst = 0;
    step();

    // ADDIU sign-extends the immediate
    op = ADDIU; rs_addr = 3; reg_data_1 = 32'h10; imm = 16'hFFFF;
    issue("addiu", 32'h10, 32'hFFFF_FFFF);

    // ORI zero-extends; MEM bypass supplies rs
    clr(); op = ORI; rs_addr = 6; reg_data_1 = 32'h99; imm = 16'h8001;
    mem_we = 1; mem_waddr = 6; mem_wdata = 32'hB0B0;
    issue("ori", 32'hB0B0, 32'h8001);

    // EX beats MEM beats register file
    clr(); op = SPECIAL; rs_addr = 4; rt_addr = 4; reg_data_1 = 32'h55; reg_data_2 = 32'h66;
    ex_we = 1; ex_waddr = 4; ex_wdata = 32'hA; mem_we = 1; mem_waddr = 4; mem_wdata = 32'hB;
    issue("special ex", 32'hA, 32'hA);
    ex_waddr = 0; mem_waddr = 0; rs_addr = 0; rt_addr = 0;
    issue("special r0", 32'h0, 32'h0);

    // Non-load EX beats the register file for rt only
    clr(); op = BEQ; rs_addr = 2; rt_addr = 9; reg_data_1 = 32'h22; reg_data_2 = 32'h99;
    ex_we = 1; ex_waddr = 9; ex_wdata = 32'hE9;
    issue("beq ex", 32'h22, 32'hE9);

    // JAL wraps, LUI shifts, unknown opcode zeroes
    clr(); op = JAL; pc = 32'hFFFF_FFFC;
    issue("jal", 32'h4, 32'h0);
    clr(); op = LUI; imm = 16'h1234; rs_addr = 3; reg_data_1 = 32'h77;
    issue("lui", 32'h0, 32'h1234_0000);
    clr(); op = 6'b111110; rs_addr = 3; reg_data_1 = 32'h77; imm = 16'h5;
    issue("unknown", 32'h0, 32'h0);

    // No hazard without in_valid, or when the load targets r0
    clr(); op = BEQ; rt_addr = 7; ex_we = 1; ex_is_load = 1; ex_waddr = 7;
    #1 chk("nohaz invalid", load_use_stall, 1'b0);
    in_valid = 1; rt_addr = 0; ex_waddr = 0;
    #1 chk("nohaz r0", load_use_stall, 1'b0);
    in_valid = 0;
    step();

    // Load-use on rt held three cycles
    clr(); op = BEQ; rs_addr = 1; rt_addr = 7; reg_data_1 = 32'h11; reg_data_2 = 32'h77;
    ex_we = 1; ex_is_load = 1; ex_waddr = 7; ex_wdata = 32'hDEAD; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("luse stall", load_use_stall, 1'b1);
      chk("luse in_ready", in_ready, 1'b0);
      step();
    end
    chk("luse no capture", out_valid, 1'b0);
    chk("luse count", stall_cycles, 4'd3);
    ex_we = 0; ex_is_load = 0;
    issue("luse release", 32'h11, 32'h77);
    chk("luse count hold", stall_cycles, 4'd3);

    // Back-pressure
    clr(); op = ADDIU; rs_addr = 2; reg_data_1 = 32'h20; imm = 16'h1;
    issue("bp first", 32'h20, 32'h1);
    clr(); op = ORI; rs_addr = 5; reg_data_1 = 32'h50; imm = 16'h2; out_ready = 0; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("bp in_ready", in_ready, 1'b0);
      step();
      chk("bp valid", out_valid, 1'b1);
      chk("bp op1", operand_1, 32'h20);
      chk("bp op2", operand_2, 32'h1);
    end
    out_ready = 1;
    issue("bp second", 32'h50, 32'h2);

    // Two more stall cycles, capture, then async reset mid-cycle
    clr(); op = ADDIU; rs_addr = 8; reg_data_1 = 32'h8; imm = 16'h3;
    ex_we = 1; ex_is_load = 1; ex_waddr = 8; in_valid = 1;
    step(); step();
    ex_we = 0; ex_is_load = 0;
    issue("pre-rst", 32'h8, 32'h3);
    chk("pre-rst count", stall_cycles, 4'd5);
    #2 rst = 1;
    #1 chk("arst valid", out_valid, 1'b0);
    chk("arst op1", operand_1, 32'h0);
    chk("arst op2", operand_2, 32'h0);
    chk("arst count", stall_cycles, 4'd0);
    @(negedge clk);
    rst = 0;

    // Counter saturates at all-ones
    clr(); op = SPECIAL; rs_addr = 12; ex_we = 1; ex_is_load = 1; ex_waddr = 12; in_valid = 1;
    for (int i = 0; i < 20; i++) step();
    chk("sat count", stall_cycles, 4'hF);
    clr();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_operand_pipe.md
Name: id_operand_pipe

Overview:
- Parametrised successor to the ID-stage operand generator.
- Selects operand_1/operand_2 per opcode, from the register file, EX/MEM bypass, immediates or PC.
- Registers the result into the ID/EX boundary with a valid/ready handshake.
- Detects load-use hazards, stalls on them, and counts stall cycles for performance monitoring.

Parameters:
- DATA_W, 32, operand/data width; must be even and ≥ 16 + 2.
- REG_ADDR_W, 5, register address width.
- OP_W, 6, opcode width.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- op  in  OP_W  opcode.
- imm  in  DATA_W/2  immediate field.
- pc  in  DATA_W  PC of the instruction.
- rs_addr  in  REG_ADDR_W  source register 1 address.
- rt_addr  in  REG_ADDR_W  source register 2 address.
- reg_data_1  in  DATA_W  register-file read for rs.
- reg_data_2  in  DATA_W  register-file read for rt.
- ex_we  in  1  EX-stage instruction writes a register.
- ex_waddr  in  REG_ADDR_W  EX destination register.
- ex_wdata  in  DATA_W  EX result.
- ex_is_load  in  1  EX instruction is a load; ex_wdata not yet valid.
- mem_we  in  1  MEM-stage write enable.
- mem_waddr  in  REG_ADDR_W  MEM destination register.
- mem_wdata  in  DATA_W  MEM result.
- out_valid  out  1  operand register holds a valid instruction.
- out_ready  in  1  EX accepts.
- operand_1  out  DATA_W  registered operand 1.
- operand_2  out  DATA_W  registered operand 2.
- load_use_stall  out  1  combinational: hazard is blocking acceptance this cycle.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with load_use_stall=1.

Behaviour:
- Opcodes: ADDIU=001001, ORI=001101, LUI=001111, BEQ=000100, BNE=000101, JAL=000011, SPECIAL=000000.
- Operand selection:
  - ADDIU: op1 = src1; op2 = sign-extended imm.
  - ORI: op1 = src1; op2 = zero-extended imm.
  - LUI: op1 = 0; op2 = {imm, DATA_W/2 zeros}.
  - BEQ/BNE: op1 = src1; op2 = src2.
  - JAL: op1 = pc + 8 (modulo 2^DATA_W, wraps); op2 = 0.
  - SPECIAL: op1 = src1; op2 = src2.
  - Any other opcode: both operands 0.
- Source usage: use_rs is true for ADDIU/ORI/BEQ/BNE/SPECIAL; use_rt is true for BEQ/BNE/SPECIAL.
- Bypass for srcN (N = rs or rt):
  - Priority EX > MEM > register file.
  - EX hit: ex_we && !ex_is_load && ex_waddr == addr && addr != 0.
  - MEM hit: mem_we && mem_waddr == addr && addr != 0.
  - Address 0 always reads 0, regardless of reg_data.
- Hazard: load_use_stall = in_valid && ex_we && ex_is_load && ex_waddr != 0 && ((use_rs && ex_waddr == rs_addr) || (use_rt && ex_waddr == rt_addr)).
- Handshake:
  - in_ready = (!out_valid || out_ready) && !load_use_stall.
  - Accept = in_valid && in_ready → operand_1/2 load the selected values; out_valid = 1.
  - out_valid && out_ready && !accept → out_valid = 0; operands hold their values.
  - Outputs hold stable while out_valid && !out_ready.
  - Latency: 1 cycle from accept to out_valid.
  - Full throughput when out_ready stays high.
- Stall counter: increments by 1 each cycle load_use_stall = 1; saturates at all-ones and does not wrap.
- Reset (asynchronous, mid-operation included): out_valid = 0, operand_1 = 0, operand_2 = 0, stall_cycles = 0. Any in-flight instruction is discarded. load_use_stall follows its inputs.
- in_valid = 0: no hazard is raised and nothing is captured.

Test Plan:
- ADDIU, rs = 3, reg_data_1 = 0x10, imm = 0xFFFF, no bypass → next cycle out_valid = 1, op1 = 0x10, op2 = 0xFFFFFFFF.
- SPECIAL, rs = rt = 4; ex_we = 1, ex_waddr = 4, ex_wdata = 0xA; mem_we = 1, mem_waddr = 4, mem_wdata = 0xB → op1 = op2 = 0xA (EX wins). Repeat with rs = rt = 0 → both operands 0.
- BEQ, rt = 7; ex_is_load = 1, ex_we = 1, ex_waddr = 7, held 3 cycles → load_use_stall = 1 and in_ready = 0 for 3 cycles; stall_cycles = 3; capture occurs on the 4th cycle after the load clears.
- JAL with pc = 0xFFFFFFFC → op1 = 0x00000004, op2 = 0. LUI with imm = 0x1234 → op1 = 0, op2 = 0x12340000.
- Back-pressure: out_ready = 0 for 2 cycles with in_valid = 1 → operands stable, in_ready = 0; out_ready = 1 → the next instruction is captured the following cycle.
- Assert rst while out_valid = 1 and stall_cycles = 5 → immediately out_valid = 0, operands = 0, stall_cycles = 0.
